// File: rtl/rx_tlp_scheduler_pkg.sv
// Shared types and defaults for the RX TLP scheduler slice.
package rx_sched_pkg;

   // Width of every qword count carried with a request (1..16, 16 = 5'b10000).
   localparam int QW_W        = 5;
   // Width of the huge-page offset; must hold HP_QW itself.
   localparam int HP_W        = 19;

   localparam int MAX_QW_DEF  = 16;
   localparam int HP_QW_DEF   = 262144;
   localparam int TIMEOUT_DEF = 1024;

   // One-hot scheduler states.
   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_TRIG = 4'b0010,
      ST_LAST = 4'b0100,
      ST_CHG  = 4'b1000
   } sched_state_e;

   // Smallest counter width able to hold the values 0..n-1 (at least 1 bit).
   function automatic int cnt_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rx_tlp_scheduler_if.sv
// Bus between the RX scheduler and the clk_in side of the RX trigger synchroniser.
//
// Handshake: each request output (trigger_tlp_out, send_last_tlp_out,
// change_huge_page_out) is a level. Once raised it stays high, together with
// qwords_to_send_out, until its ack input pulses high for exactly one cycle;
// the request drops on the edge that samples the ack. trigger_tlp_ack_in
// acknowledges trigger_tlp_out; change_huge_page_ack_in acknowledges both
// send_last_tlp_out and change_huge_page_out. An ack that arrives while no
// matching request is up is ignored. At most one request is high at a time.
interface rx_tlp_scheduler_if
   import rx_sched_pkg::*;
#(
   parameter int AW = 12
);
   logic               enable_in;
   logic [AW-1:0]      wr_ptr_in;
   logic [AW-1:0]      rd_ptr_out;
   logic               trigger_tlp_out;
   logic               trigger_tlp_ack_in;
   logic               send_last_tlp_out;
   logic               change_huge_page_out;
   logic               change_huge_page_ack_in;
   logic [QW_W-1:0]    qwords_to_send_out;
   logic [HP_W-1:0]    hp_offset_out;
   logic               busy_out;
   sched_state_e       state_dbg_out;

   // Scheduler side.
   modport master (
      input  enable_in,
      input  wr_ptr_in,
      input  trigger_tlp_ack_in,
      input  change_huge_page_ack_in,
      output rd_ptr_out,
      output trigger_tlp_out,
      output send_last_tlp_out,
      output change_huge_page_out,
      output qwords_to_send_out,
      output hp_offset_out,
      output busy_out,
      output state_dbg_out
   );

   // Synchroniser / buffer-writer side.
   modport slave (
      output enable_in,
      output wr_ptr_in,
      output trigger_tlp_ack_in,
      output change_huge_page_ack_in,
      input  rd_ptr_out,
      input  trigger_tlp_out,
      input  send_last_tlp_out,
      input  change_huge_page_out,
      input  qwords_to_send_out,
      input  hp_offset_out,
      input  busy_out,
      input  state_dbg_out
   );
endinterface

// File: rtl/rx_tlp_scheduler_chunk_calc.sv
// Combinational sizing of the next TLP: min(MAX_QW, pending, page_rem) plus
// the compares the scheduler uses to pick its next request.
module rx_chunk_calc
   import rx_sched_pkg::*;
#(
   parameter int AW     = 12,
   parameter int MAX_QW = MAX_QW_DEF,
   parameter int HP_QW  = HP_QW_DEF
) (
   input  logic [AW-1:0]   pending_i,
   input  logic [HP_W-1:0] hp_offset_i,
   output logic [QW_W-1:0] chunk_o,
   output logic            page_empty_o,
   output logic            full_ok_o,
   output logic            has_data_o
);
   // Common compare width, wide enough for the pointer span and the page size.
   localparam int CW = ((AW > HP_W) ? AW : HP_W) + 2;

   logic [CW-1:0] pend_w;
   logic [CW-1:0] rem_w;
   logic [CW-1:0] max_w;

   assign pend_w = CW'(pending_i);
   assign max_w  = CW'(MAX_QW);
   // hp_offset never exceeds HP_QW, so this never goes negative.
   assign rem_w  = CW'(HP_QW) - CW'(hp_offset_i);

   assign has_data_o   = (pending_i != '0);
   assign page_empty_o = (rem_w == '0);
   // A full TLP is ready either when MAX_QW qwords are waiting or when the
   // waiting data fills the rest of the current page exactly or beyond.
   assign full_ok_o    = (pend_w >= max_w) || ((pend_w >= rem_w) && !page_empty_o);

   // Pick the smallest of the three limits; any value below MAX_QW fits QW_W.
   always_comb begin
      chunk_o = QW_W'(MAX_QW);
      if ((max_w <= pend_w) && (max_w <= rem_w)) begin
         chunk_o = QW_W'(MAX_QW);
      end else if (pend_w <= rem_w) begin
         chunk_o = pend_w[QW_W-1:0];
      end else begin
         chunk_o = rem_w[QW_W-1:0];
      end
   end

endmodule

// File: rtl/rx_tlp_scheduler.sv
// RX DMA scheduler: turns buffer fill level and huge-page usage into
// trigger / flush / page-change requests and owns the buffer read pointer.
module rx_tlp_scheduler
   import rx_sched_pkg::*;
#(
   parameter int AW      = 12,
   parameter int MAX_QW  = MAX_QW_DEF,
   parameter int HP_QW   = HP_QW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk_in,
   input  logic               reset_n_clk_in,
   rx_tlp_scheduler_if.master bus
);
   localparam int              IC_W   = cnt_w(TIMEOUT);
   localparam logic [IC_W-1:0] IC_MAX = IC_W'(TIMEOUT - 1);

   sched_state_e    state_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [HP_W-1:0] hp_offset_q;
   logic [QW_W-1:0] qwords_q;
   logic            trig_q;
   logic            last_q;
   logic            chg_q;
   logic [IC_W-1:0] idle_cnt_q;
   logic [IC_W-1:0] idle_cnt_d;

   logic [AW-1:0]   pending;
   logic [QW_W-1:0] chunk;
   logic            page_empty;
   logic            full_ok;
   logic            has_data;
   logic            go_chg;
   logic            go_trig;
   logic            go_last;
   logic            issue;

   // Modular distance between writer and reader.
   assign pending = bus.wr_ptr_in - rd_ptr_q;

   rx_chunk_calc #(
      .AW     (AW),
      .MAX_QW (MAX_QW),
      .HP_QW  (HP_QW)
   ) u_chunk_calc (
      .pending_i    (pending),
      .hp_offset_i  (hp_offset_q),
      .chunk_o      (chunk),
      .page_empty_o (page_empty),
      .full_ok_o    (full_ok),
      .has_data_o   (has_data)
   );

   // Request selection in IDLE, in priority order: page change, full TLP, flush.
   always_comb begin
      go_chg  = 1'b0;
      go_trig = 1'b0;
      go_last = 1'b0;
      if ((state_q == ST_IDLE) && bus.enable_in) begin
         if (page_empty) begin
            go_chg = 1'b1;
         end else if (full_ok) begin
            go_trig = 1'b1;
         end else if (has_data && (idle_cnt_q == IC_MAX)) begin
            go_last = 1'b1;
         end
      end
   end

   assign issue = go_chg | go_trig | go_last;

   // Idle counter: restarts on new data or a new request, else counts up to
   // TIMEOUT-1 while anything is waiting.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if ((bus.wr_ptr_in != wr_ptr_q) || issue) begin
         idle_cnt_d = '0;
      end else if (has_data && (idle_cnt_q != IC_MAX)) begin
         idle_cnt_d = idle_cnt_q + IC_W'(1);
      end
   end

   // Idle tracking registers: last seen write pointer and the idle counter.
   always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
      if (!reset_n_clk_in) begin
         wr_ptr_q   <= '0;
         idle_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= bus.wr_ptr_in;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   // Scheduler FSM with registered request outputs and pointer bookkeeping.
   always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
      if (!reset_n_clk_in) begin
         state_q     <= ST_IDLE;
         rd_ptr_q    <= '0;
         hp_offset_q <= '0;
         qwords_q    <= '0;
         trig_q      <= 1'b0;
         last_q      <= 1'b0;
         chg_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (go_chg) begin
                  chg_q   <= 1'b1;
                  state_q <= ST_CHG;
               end else if (go_trig) begin
                  trig_q   <= 1'b1;
                  qwords_q <= chunk;
                  state_q  <= ST_TRIG;
               end else if (go_last) begin
                  // Not full and not page-limited, so chunk equals pending here.
                  last_q   <= 1'b1;
                  qwords_q <= chunk;
                  state_q  <= ST_LAST;
               end
            end
            ST_TRIG: begin
               if (bus.trigger_tlp_ack_in) begin
                  trig_q      <= 1'b0;
                  rd_ptr_q    <= rd_ptr_q + AW'(qwords_q);
                  hp_offset_q <= hp_offset_q + HP_W'(qwords_q);
                  state_q     <= ST_IDLE;
               end
            end
            ST_LAST: begin
               // A flush closes the page, so the page change follows directly.
               if (bus.change_huge_page_ack_in) begin
                  last_q      <= 1'b0;
                  rd_ptr_q    <= rd_ptr_q + AW'(qwords_q);
                  hp_offset_q <= hp_offset_q + HP_W'(qwords_q);
                  chg_q       <= 1'b1;
                  state_q     <= ST_CHG;
               end
            end
            ST_CHG: begin
               if (bus.change_huge_page_ack_in) begin
                  chg_q       <= 1'b0;
                  hp_offset_q <= '0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               trig_q  <= 1'b0;
               last_q  <= 1'b0;
               chg_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rd_ptr_out           = rd_ptr_q;
   assign bus.trigger_tlp_out      = trig_q;
   assign bus.send_last_tlp_out    = last_q;
   assign bus.change_huge_page_out = chg_q;
   assign bus.qwords_to_send_out   = qwords_q;
   assign bus.hp_offset_out        = hp_offset_q;
   assign bus.busy_out             = (state_q != ST_IDLE);
   assign bus.state_dbg_out        = state_q;

endmodule
